irq_capture_arb_4: RTL and testbench
====================================

IRQ_CAPTURE_ARB_4 -- requirements
Module: irq_capture_arb_4

Interface
REQ-001 Parameter CNT_W, default 8: width of the serviced-event counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  raw request lines, synchronous to clk; a rising edge is one event. Bit 3 has highest priority.
REQ-005 mask  input  4  1 = channel masked from arbitration; pending capture still occurs.
REQ-006 ack  input  1  consumer accepts the presented event.
REQ-007 irq_valid  output  1  an event is presented on irq_id.
REQ-008 irq_id  output  2  index of the presented channel.
REQ-009 dis  output  1  1 = no unmasked pending channel and irq_valid=0.
REQ-010 pending  output  4  captured, not-yet-serviced events.
REQ-011 overrun  output  4  sticky flag: a second edge arrived while the channel was already pending.
REQ-012 svc_cnt  output  CNT_W  count of accepted events.

Function
REQ-013 Edge detect: req_d SHALL be a 1-cycle registered copy of req; edge[n] = req[n] & ~req_d[n].
REQ-014 On edge[n] at a clock edge, pending[n] SHALL become 1 at that edge, so it is visible the following cycle.
REQ-015 FSM states SHALL be IDLE, BUSY and GAP, encoded in 2 bits; an illegal code SHALL return to IDLE.
REQ-016 In IDLE, if (pending & ~mask) != 0, the FSM SHALL go to BUSY, register irq_id = index of the highest set bit of (pending & ~mask), and set irq_valid=1 at the same edge.
REQ-017 In BUSY, irq_valid and irq_id SHALL hold stable until ack=1, regardless of mask or new edges.
REQ-018 On ack=1 in BUSY:
- pending[irq_id] SHALL clear.
- overrun[irq_id] SHALL clear.
- irq_valid SHALL go to 0.
- svc_cnt SHALL increment by 1, wrapping modulo 2^CNT_W.
- The FSM SHALL go to GAP.
REQ-019 GAP SHALL last exactly one cycle and then return to IDLE; minimum spacing between two presentations is therefore 2 idle cycles after ack.
REQ-020 ack while not in BUSY SHALL be ignored: no state, flag or counter change.
REQ-021 Edge on a channel whose pending bit is 1 and which is not being cleared that cycle SHALL set overrun[n]; pending stays 1.
REQ-022 Edge on the channel cleared by ack in the same cycle SHALL leave pending[n]=1 and overrun[n] unchanged (cleared), because the new event wins.
REQ-023 Edges on multiple channels in one cycle SHALL all be captured.
REQ-024 dis SHALL be combinational: dis = ~irq_valid & ((pending & ~mask) == 0).
REQ-025 Latency from req rising (sampled at edge k) to irq_valid=1 in IDLE SHALL be 2 cycles (edge k+1).

Reset
REQ-026 While rst_n=0, the following SHALL be held at their reset values:
- state = IDLE.
- req_d = 0.
- pending = 0.
- overrun = 0.
- irq_valid = 0.
- irq_id = 0.
- svc_cnt = 0.
- dis = 1.
REQ-027 Reset mid-BUSY SHALL drop irq_valid immediately, without waiting for a clock edge.
REQ-028 The first edge detection after reset release SHALL treat req_d=0, so a req held high through reset counts as one event.

Verification
REQ-029 Single event: req=0001 pulsed at cycle 0 -> pending=0001 at cycle 1, irq_valid=1 and irq_id=0 at cycle 2; ack at cycle 3 -> pending=0000, svc_cnt=1, dis=1 at cycle 4.
REQ-030 Priority: req edges 0110 in the same cycle -> irq_id=2 first; after ack and GAP, irq_id=1; svc_cnt=2.
REQ-031 Mask: pending=1000 with mask=1000 -> dis=1, irq_valid stays 0; clearing mask -> irq_valid=1 and irq_id=3 next cycle; setting mask=1000 during BUSY does not drop irq_valid.
REQ-032 Overrun and simultaneous clear:
- A second edge on ch0 while pending -> overrun=0001.
- An edge on ch0 in the same cycle as its ack -> pending[0]=1, overrun[0]=0.
REQ-033 Wrap: CNT_W=8, 256 acks -> svc_cnt=0.
REQ-034 Reset mid-BUSY with req=1111 held high -> all outputs at reset values while rst_n=0; after release, pending=1111 one cycle later.

Source files
------------

// File: rtl/irq_capture_arb_4.sv
// Purpose: four-channel rising-edge IRQ capture with fixed-priority presentation (ch3 highest).
// Latency: req rise sampled at edge k -> pending after edge k, irq_valid after edge k+1.
// Backpressure: a presented event holds until ack; one GAP cycle follows every ack.
module irq_capture_arb_4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       mask,
    input  logic             ack,
    output logic             irq_valid,
    output logic [1:0]       irq_id,
    output logic             dis,
    output logic [3:0]       pending,
    output logic [3:0]       overrun,
    output logic [CNT_W-1:0] svc_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       req_d;
    logic [3:0]       rise;
    logic [3:0]       avail;
    logic [3:0]       clr;
    logic [3:0]       pending_nxt;
    logic [3:0]       overrun_nxt;
    logic [1:0]       top_id;
    logic [1:0]       id_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign rise  = req & ~req_d;
    assign avail = pending & ~mask;

    always_comb begin
        top_id = 2'd0;
        if (avail[3])      top_id = 2'd3;
        else if (avail[2]) top_id = 2'd2;
        else if (avail[1]) top_id = 2'd1;
    end

    always_comb begin
        state_nxt = IDLE;
        id_nxt    = irq_id;
        clr       = 4'b0000;
        cnt_nxt   = svc_cnt;
        case (state)
            IDLE: begin
                if (|avail) begin
                    state_nxt = BUSY;
                    id_nxt    = top_id;
                end
            end
            BUSY: begin
                if (ack) begin
                    state_nxt = GAP;
                    clr       = 4'b0001 << irq_id;
                    cnt_nxt   = svc_cnt + CNT_W'(1);
                end else begin
                    state_nxt = BUSY;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A fresh edge on the channel being acked re-arms it; the old overrun is retired with it.
    assign pending_nxt = (pending & ~clr) | rise;
    assign overrun_nxt = (overrun & ~clr) | (rise & pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_d   <= 4'b0000;
            pending <= 4'b0000;
            overrun <= 4'b0000;
            irq_id  <= 2'd0;
            svc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            req_d   <= req;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            irq_id  <= id_nxt;
            svc_cnt <= cnt_nxt;
        end
    end

    // Decoded straight from the state register so reset drops it asynchronously.
    assign irq_valid = (state == BUSY);
    assign dis       = ~irq_valid & ~(|avail);

endmodule

// File: tb/tb_irq_capture_arb_4.sv
// Bench for irq_capture_arb_4: table-driven cycle vectors through a scoreboard queue,
// plus hand sequences for counter wrap and reset during a presentation.
module tb_irq_capture_arb_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] mask = 4'b0000;
    logic       ack = 1'b0;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic       dis;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [7:0] svc_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    irq_capture_arb_4 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .ack       (ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .dis       (dis),
        .pending   (pending),
        .overrun   (overrun),
        .svc_cnt   (svc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic       valid;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovr;
        logic       dis;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input logic a,
                                input logic v, input logic [1:0] id, input logic [3:0] p,
                                input logic [3:0] o, input logic d, input logic [7:0] c);
        vec_t t;
        t.req = r; t.mask = m; t.ack = a; t.valid = v; t.id = id;
        t.pend = p; t.ovr = o; t.dis = d; t.cnt = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"},   32'(irq_valid), 32'd0);
        check({tag, "_id"},      32'(irq_id),    32'd0);
        check({tag, "_pending"}, 32'(pending),   32'd0);
        check({tag, "_overrun"}, 32'(overrun),   32'd0);
        check({tag, "_cnt"},     32'(svc_cnt),   32'd0);
        check({tag, "_dis"},     32'(dis),       32'd1);
    endtask

    // Drive one cycle of stimulus at the current negedge, compare after the following posedge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        req = v.req; mask = v.mask; ack = v.ack;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("v%0d_valid", idx),   32'(irq_valid), 32'(e.valid));
        if (e.valid) check($sformatf("v%0d_id", idx), 32'(irq_id), 32'(e.id));
        check($sformatf("v%0d_pending", idx), 32'(pending),   32'(e.pend));
        check($sformatf("v%0d_overrun", idx), 32'(overrun),   32'(e.ovr));
        check($sformatf("v%0d_dis", idx),     32'(dis),       32'(e.dis));
        check($sformatf("v%0d_cnt", idx),     32'(svc_cnt),   32'(e.cnt));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!irq_valid && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!irq_valid) begin
            n_chk++;
            $display("FAIL %s: irq_valid timeout after %0d cycles, expected 1", name, budget);
        end
    endtask

    initial begin
        //            req   mask  ack  val id   pend  ovr   dis cnt
        tbl.push_back(mk(4'h1, 4'h0, 0, 0, 2'd0, 4'h1, 4'h0, 0, 8'd0)); // single event
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd0, 4'h1, 4'h0, 0, 8'd0));
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd0, 4'h1, 4'h0, 0, 8'd0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd0, 4'h0, 4'h0, 1, 8'd1));
        tbl.push_back(mk(4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 4'h0, 1, 8'd1));
        tbl.push_back(mk(4'h6, 4'h0, 0, 0, 2'd0, 4'h6, 4'h0, 0, 8'd1)); // priority 2 over 1
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd2, 4'h6, 4'h0, 0, 8'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd2, 4'h2, 4'h0, 0, 8'd2));
        tbl.push_back(mk(4'h0, 4'h0, 0, 0, 2'd2, 4'h2, 4'h0, 0, 8'd2)); // GAP
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd1, 4'h2, 4'h0, 0, 8'd2));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 1, 8'd3));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 1, 8'd3)); // ack in GAP ignored
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h0, 1, 8'd3)); // ack in IDLE ignored
        tbl.push_back(mk(4'h8, 4'h8, 0, 0, 2'd1, 4'h8, 4'h0, 1, 8'd3)); // masked pending
        tbl.push_back(mk(4'h8, 4'h8, 0, 0, 2'd1, 4'h8, 4'h0, 1, 8'd3));
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd3, 4'h8, 4'h0, 0, 8'd3)); // unmask
        tbl.push_back(mk(4'h0, 4'h8, 0, 1, 2'd3, 4'h8, 4'h0, 0, 8'd3)); // mask during BUSY
        tbl.push_back(mk(4'h0, 4'h8, 1, 0, 2'd3, 4'h0, 4'h0, 1, 8'd4));
        tbl.push_back(mk(4'h0, 4'h0, 0, 0, 2'd3, 4'h0, 4'h0, 1, 8'd4));
        tbl.push_back(mk(4'h1, 4'h0, 0, 0, 2'd3, 4'h1, 4'h0, 0, 8'd4)); // overrun
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd0, 4'h1, 4'h0, 0, 8'd4));
        tbl.push_back(mk(4'h1, 4'h0, 0, 1, 2'd0, 4'h1, 4'h1, 0, 8'd4));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd0, 4'h0, 4'h0, 1, 8'd5));
        tbl.push_back(mk(4'h1, 4'h0, 0, 0, 2'd0, 4'h1, 4'h0, 0, 8'd5)); // edge during GAP
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd0, 4'h1, 4'h0, 0, 8'd5));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 2'd0, 4'h1, 4'h0, 0, 8'd6)); // edge with own ack
        tbl.push_back(mk(4'h0, 4'h0, 0, 0, 2'd0, 4'h1, 4'h0, 0, 8'd6));
        tbl.push_back(mk(4'h0, 4'h0, 0, 1, 2'd0, 4'h1, 4'h0, 0, 8'd6));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 2'd0, 4'h0, 4'h0, 1, 8'd7));
        tbl.push_back(mk(4'h0, 4'h0, 0, 0, 2'd0, 4'h0, 4'h0, 1, 8'd7));

        // Reset values
        @(posedge clk);
        #1 check_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Counter wrap over 256 accepted events
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req = 4'h1;
            @(posedge clk);
            @(negedge clk);
            req = 4'h0;
            wait_valid("wrap_wait", 8);
            ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ack = 1'b0;
            if (i == 254) check("wrap_cnt_255", 32'(svc_cnt), 32'd255);
        end
        check("wrap_cnt_0", 32'(svc_cnt), 32'd0);
        check("wrap_idle_valid", 32'(irq_valid), 32'd0);

        // Reset during BUSY with all requests held high
        @(posedge clk);
        @(negedge clk);
        req = 4'hf;
        wait_valid("busy_wait", 8);
        check("busy_id3", 32'(irq_id), 32'd3);
        check("busy_overrun", 32'(overrun), 32'd0);
        #2 rst_n = 1'b0;
        #1 check("async_valid_drop", 32'(irq_valid), 32'd0);
        check("async_dis", 32'(dis), 32'd1);
        repeat (2) @(posedge clk);
        #1 check_reset_vals("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_pending", 32'(pending), 32'hf);
        check("post_rst_valid", 32'(irq_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_present", 32'(irq_valid), 32'd1);
        check("post_rst_id", 32'(irq_id), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
